mipi_hs_tx_framer: RTL and testbench
====================================

Name: mipi_hs_tx_framer

Overview:
Transmit-side framer for one MIPI D-PHY HS lane pair, 16 bits (2 bytes) per byte_clk. It takes a byte payload over a valid/ready stream and wraps it in an HS burst: prepare delay, leader zeros, SoT sync byte 0xB8, payload, then HS-trail. It sits between the packet builder and the lane serializer, and produces the word stream that the receive-side byte aligner must lock onto.

Parameters:
PREP_CYCLES, 4, byte_clk cycles with hs_req=1 before the first valid word (1..15)
ZERO_WORDS, 2, 0x0000 leader words before the sync word (0..15)
TRAIL_WORDS, 2, trail words after the payload (1..15)
EXIT_CYCLES, 3, cycles with hs_req=0 after the trail before returning to idle (1..15)

Ports:
byte_clk  in  1  lane byte clock
sys_rst_n  in  1  reset
tx_start  in  1  one-cycle start pulse; ignored unless busy=0
tx_len  in  16  payload length in bytes, latched on an accepted tx_start
s_valid  in  1  payload word valid
s_ready  out  1  payload word accepted when s_valid & s_ready
s_data  in  16  payload; [7:0] is the earlier byte on the wire, [15:8] the later byte
busy  out  1  high from an accepted start until the end of EXIT
done  out  1  one-cycle pulse on EXIT->IDLE
underflow  out  1  one-cycle pulse when the burst is aborted because payload was starved
hs_req  out  1  HS drive request to the lane driver
data_out_valid  out  1  data_out carries a line word
data_out  out  16  line word; [7:0] goes first on the wire, bit 0 of each byte first

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low; clock is byte_clk. All outputs reset to 0, state to IDLE, all counters to 0.
- States and transitions:
  - IDLE -> PREP on tx_start. Latch tx_len into rem_bytes.
  - PREP: hs_req=1, data_out_valid=0, for PREP_CYCLES cycles.
  - ZERO: ZERO_WORDS words of 0x0000, data_out_valid=1. If ZERO_WORDS=0, skip this state.
  - SYNC: one word 0xB800 (leader 0x00 first on the wire, then 0xB8).
  - DATA: s_ready=1 combinationally while in DATA and rem_bytes>0. Each accepted beat outputs s_data on the next cycle (1-cycle registered latency) and decrements rem_bytes by 2.
    - Odd final beat (rem_bytes=1): send s_data[7:0] as the low byte; the upper byte is the trail byte, and rem_bytes goes to 0.
    - When rem_bytes reaches 0, go to TRAIL.
  - TRAIL: TRAIL_WORDS words, each equal to the trail byte repeated in both halves. Trail byte = {8{~last_bit}}, where last_bit is bit 7 of the last byte sent.
  - EXIT: hs_req=0, data_out_valid=0, for EXIT_CYCLES cycles; then done pulses and state returns to IDLE.
- hs_req is 1 from PREP through TRAIL inclusive.
- data_out_valid is 1 exactly in ZERO, SYNC, DATA output and TRAIL cycles, with no gaps inside a burst.
- tx_len=0: SYNC is followed directly by TRAIL. last_bit=1 (MSB of 0xB8), so trail words are 0x0000.
- Underflow: s_valid=0 in a DATA cycle with rem_bytes>0 -> pulse underflow, drop the remaining payload, and go to TRAIL using the last byte actually sent. If nothing was sent, use the sync byte.
- tx_start while busy=1: ignored, with no effect on the current burst.
- Reset mid-burst: outputs and hs_req return to 0 immediately. No trail is emitted.
- Counters must not wrap; every state counter is cleared on entry to its state.

Test Plan:
1. Defaults, tx_len=4, s_data 0x2211 then 0x4433 -> 4 cycles valid=0 / hs_req=1, then words 0x0000, 0x0000, 0xB800, 0x2211, 0x4433, 0xFFFF, 0xFFFF, then 3 idle cycles, then done. (0x44 has bit7=0, so trail byte is 0xFF.)
2. tx_len=3, s_data 0x0201 then 0x0080 -> payload words 0x0201, 0x0080 with the low byte 0x80 and upper byte 0x00 as trail byte; trail words 0x0000, 0x0000.
3. tx_len=0 -> words 0x0000, 0x0000, 0xB800, 0x0000, 0x0000; s_ready is never asserted; done pulses once.
4. tx_len=6, s_valid dropped after the first beat 0x7F01 -> underflow pulse, trail words 0xFFFF x2, done. Total valid words = 6.
5. tx_start pulsed again during DATA -> no change to the burst; busy stays 1 until done.
6. sys_rst_n asserted during TRAIL -> hs_req, data_out_valid and busy go to 0 immediately. A new tx_start after release produces a complete burst.

Source files
------------

// File: rtl/mipi_hs_tx_framer.sv
// Transmit framer for one D-PHY HS lane pair: wraps a 2-byte/cycle payload stream in an
// HS burst (prepare, leader zeros, SoT sync 0xB8, payload, trail, exit).
module mipi_hs_tx_framer #(
    parameter int unsigned PREP_CYCLES = 4,
    parameter int unsigned ZERO_WORDS  = 2,
    parameter int unsigned TRAIL_WORDS = 2,
    parameter int unsigned EXIT_CYCLES = 3
) (
    input  logic        byte_clk,
    input  logic        sys_rst_n,
    input  logic        tx_start,
    input  logic [15:0] tx_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        busy,
    output logic        done,
    output logic        underflow,
    output logic        hs_req,
    output logic        data_out_valid,
    output logic [15:0] data_out
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam logic [WORD_W-1:0] SYNC_WORD = 16'hB800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              last_bit_q, last_bit_d;
    logic              busy_d, done_d, underflow_d, hs_req_d, valid_d;
    logic [WORD_W-1:0] data_d;
    logic [BYTE_W-1:0] trail_byte;
    logic [BYTE_W-1:0] odd_trail_byte;

    assign s_ready        = (state_q == S_DATA) && (rem_q != '0);
    assign trail_byte     = {BYTE_W{~last_bit_q}};
    assign odd_trail_byte = {BYTE_W{~s_data[7]}};

    // State register and registered line outputs
    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            last_bit_q     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underflow      <= 1'b0;
            hs_req         <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            last_bit_q     <= last_bit_d;
            busy           <= busy_d;
            done           <= done_d;
            underflow      <= underflow_d;
            hs_req         <= hs_req_d;
            data_out_valid <= valid_d;
            data_out       <= data_d;
        end
    end

    // Next state and next line word; outputs appear one cycle after the state producing them
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        last_bit_d  = last_bit_q;
        done_d      = 1'b0;
        underflow_d = 1'b0;
        hs_req_d    = 1'b0;
        valid_d     = 1'b0;
        data_d      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = S_PREP;
                    cnt_d   = '0;
                    rem_d   = tx_len;
                end
            end
            S_PREP: begin
                hs_req_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PREP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (ZERO_WORDS == 0) ? S_SYNC : S_ZERO;
                end
            end
            S_ZERO: begin
                hs_req_d = 1'b1;
                valid_d  = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ZERO_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                hs_req_d   = 1'b1;
                valid_d    = 1'b1;
                data_d     = SYNC_WORD;
                last_bit_d = 1'b1;
                cnt_d      = '0;
                state_d    = (rem_q == '0) ? S_TRAIL : S_DATA;
            end
            S_DATA: begin
                hs_req_d = 1'b1;
                valid_d  = 1'b1;
                if (s_valid) begin
                    if (rem_q == LEN_W'(1)) begin
                        data_d     = {odd_trail_byte, s_data[7:0]};
                        last_bit_d = s_data[7];
                        rem_d      = '0;
                    end else begin
                        data_d     = s_data;
                        last_bit_d = s_data[15];
                        rem_d      = rem_q - LEN_W'(2);
                    end
                    if (rem_q <= LEN_W'(2)) begin
                        cnt_d   = '0;
                        state_d = S_TRAIL;
                    end
                end else begin
                    // Starved: this cycle already carries the first trail word, keeping valid gap-free
                    underflow_d = 1'b1;
                    data_d      = {2{trail_byte}};
                    rem_d       = '0;
                    if (TRAIL_WORDS == 1) begin
                        cnt_d   = '0;
                        state_d = S_EXIT;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                hs_req_d = 1'b1;
                valid_d  = 1'b1;
                data_d   = {2{trail_byte}};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TRAIL_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXIT;
                end
            end
            S_EXIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(EXIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mipi_hs_tx_framer.sv
// Bench for mipi_hs_tx_framer: bursts are expanded into expected line words from their byte
// payload at issue time; an output monitor pops and compares whatever the framer emits.
module tb_mipi_hs_tx_framer;
    localparam int unsigned PREP = 4;
    localparam int unsigned ZW   = 2;
    localparam int unsigned TW   = 2;
    localparam int unsigned EXC  = 3;

    logic        byte_clk  = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        tx_start  = 1'b0;
    logic [15:0] tx_len    = '0;
    logic        s_valid   = 1'b0;
    logic        s_ready;
    logic [15:0] s_data    = '0;
    logic        busy, done, underflow, hs_req, data_out_valid;
    logic [15:0] data_out;

    mipi_hs_tx_framer #(
        .PREP_CYCLES(PREP),
        .ZERO_WORDS (ZW),
        .TRAIL_WORDS(TW),
        .EXIT_CYCLES(EXC)
    ) dut (
        .byte_clk      (byte_clk),
        .sys_rst_n     (sys_rst_n),
        .tx_start      (tx_start),
        .tx_len        (tx_len),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .busy          (busy),
        .done          (done),
        .underflow     (underflow),
        .hs_req        (hs_req),
        .data_out_valid(data_out_valid),
        .data_out      (data_out)
    );

    always #5 byte_clk = ~byte_clk;

    typedef struct {
        int n_words;
        int uf;
    } frame_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    frame_t      frame_q[$];
    logic [7:0]  pay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the line is leader zeros, sync, bytes actually sent in wire order, then trail
    task automatic model_push(input int len, input int starve_beats);
        int         sent;
        logic [7:0] last;
        logic [7:0] t;
        frame_t     f;
        sent = (2 * starve_beats < len) ? 2 * starve_beats : len;
        last = 8'hB8;
        if (sent > 0) last = pay_q[sent-1];
        t = last[7] ? 8'h00 : 8'hFF;
        for (int i = 0; i < int'(ZW); i++) exp_q.push_back(16'h0000);
        exp_q.push_back(16'hB800);
        for (int i = 0; i < sent; i += 2) begin
            if (i + 1 < sent) exp_q.push_back({pay_q[i+1], pay_q[i]});
            else              exp_q.push_back({t, pay_q[i]});
        end
        for (int i = 0; i < int'(TW); i++) exp_q.push_back({t, t});
        f.n_words = int'(ZW) + 1 + (sent + 1) / 2 + int'(TW);
        f.uf      = (sent < len) ? 1 : 0;
        frame_q.push_back(f);
    endtask

    function automatic logic [15:0] beat(input int idx);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'($urandom);
        hi = 8'($urandom);
        if (2 * idx < pay_q.size())     lo = pay_q[2*idx];
        if (2 * idx + 1 < pay_q.size()) hi = pay_q[2*idx+1];
        return {hi, lo};
    endfunction

    task automatic fill_random(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic run_burst(input int len, input int starve_beats, input bit restart, input bit abort);
        int nbeats, to_send, idx, acc_n, busy_low;
        bit acc, finished, pulsed;
        nbeats   = (len + 1) / 2;
        to_send  = (starve_beats < nbeats) ? starve_beats : nbeats;
        idx      = 0;
        acc_n    = 0;
        busy_low = 0;
        finished = 1'b0;
        pulsed   = 1'b0;
        model_push(len, starve_beats);
        @(posedge byte_clk); #1;
        tx_start = 1'b1;
        tx_len   = 16'(len);
        s_valid  = (to_send > 0);
        s_data   = beat(0);
        @(posedge byte_clk); #1;
        tx_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge byte_clk);
            acc = s_valid && s_ready;
            if (done) finished = 1'b1;
            else if (!busy) busy_low++;
            if (!finished) begin
                @(posedge byte_clk); #1;
                if (acc) begin
                    idx++;
                    acc_n++;
                end
                tx_start = restart && (idx == 1) && !pulsed;
                if (tx_start) begin
                    pulsed = 1'b1;
                    tx_len = 16'($urandom_range(1, 30));
                end
                s_valid = (idx < to_send);
                s_data  = beat(idx);
                if (abort && exp_q.size() == int'(TW) - 1) begin
                    check("hs_req_before_reset", 32'(hs_req), 32'd1);
                    sys_rst_n = 1'b0;
                    #1;
                    check("hs_req_in_reset", 32'(hs_req), 32'd0);
                    check("valid_in_reset", 32'(data_out_valid), 32'd0);
                    check("busy_in_reset", 32'(busy), 32'd0);
                    exp_q.delete();
                    frame_q.delete();
                    s_valid  = 1'b0;
                    tx_start = 1'b0;
                    repeat (2) @(posedge byte_clk);
                    #1 sys_rst_n = 1'b1;
                    return;
                end
            end
        end
        s_valid  = 1'b0;
        tx_start = 1'b0;
        if (!finished) check("done_timeout", 32'd0, 32'd1);
        check("beats_accepted", 32'(acc_n), 32'(to_send));
        check("busy_gap", 32'(busy_low), 32'd0);
    endtask

    // Output monitor: pops one expected word per valid line word and closes a frame on done
    int words_seen = 0;
    int prep_cnt   = 0;
    int exit_cnt   = 0;
    int uf_cnt     = 0;
    always @(negedge byte_clk) begin
        logic [15:0] exp_w;
        frame_t      f;
        if (!sys_rst_n) begin
            words_seen = 0;
            prep_cnt   = 0;
            exit_cnt   = 0;
            uf_cnt     = 0;
        end else begin
            if (underflow) uf_cnt++;
            if (data_out_valid) begin
                if (words_seen == 0) check("prep_cycles", 32'(prep_cnt), 32'(PREP));
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got 0x%0h with nothing expected at %0t", data_out, $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("line_word", 32'(data_out), 32'(exp_w));
                end
                words_seen++;
            end else if (hs_req) begin
                if (words_seen == 0) prep_cnt++;
                else begin
                    n_chk++;
                    $display("FAIL valid_gap: data_out_valid=0 with hs_req=1 inside burst at %0t", $time);
                end
            end else if (words_seen > 0) begin
                exit_cnt++;
            end
            if (done) begin
                if (frame_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: done pulse with no burst pending at %0t", $time);
                end else begin
                    f = frame_q.pop_front();
                    check("word_count", 32'(words_seen), 32'(f.n_words));
                    check("underflow_pulses", 32'(uf_cnt), 32'(f.uf));
                    check("exit_cycles", 32'(exit_cnt), 32'(EXC));
                end
                words_seen = 0;
                prep_cnt   = 0;
                exit_cnt   = 0;
                uf_cnt     = 0;
            end
        end
    end

    initial begin
        int len;
        int nb;
        repeat (3) @(posedge byte_clk);
        #1;
        check("rst_hs_req", 32'(hs_req), 32'd0);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        sys_rst_n = 1'b1;

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_burst(4, 99, 1'b0, 1'b0);
        pay_q = '{8'h01, 8'h02, 8'h80};
        run_burst(3, 99, 1'b0, 1'b0);
        pay_q.delete();
        run_burst(0, 99, 1'b0, 1'b0);
        fill_random(6);
        pay_q[0] = 8'h01;
        pay_q[1] = 8'h7F;
        run_burst(6, 1, 1'b0, 1'b0);
        fill_random(8);
        run_burst(8, 99, 1'b1, 1'b0);
        fill_random(4);
        run_burst(4, 99, 1'b0, 1'b1);
        pay_q = '{8'hAA, 8'h55};
        run_burst(2, 99, 1'b0, 1'b0);

        for (int b = 0; b < 14; b++) begin
            len = int'($urandom_range(0, 13));
            nb  = (len + 1) / 2;
            fill_random(len);
            if (nb > 0 && $urandom_range(0, 2) == 0)
                run_burst(len, int'($urandom_range(0, nb - 1)), 1'b0, 1'b0);
            else
                run_burst(len, 99, $urandom_range(0, 3) == 0, 1'b0);
        end

        repeat (5) @(posedge byte_clk);
        #1;
        check("leftover_words", 32'(exp_q.size()), 32'd0);
        check("leftover_frames", 32'(frame_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
